// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug unit: state encoding, command codes and frame geometry.
package debug_pkg;
    localparam int MEM_ADDR_W  = 8;
    localparam int FRAME_BYTES = 8;

    localparam logic [31:0]           HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [MEM_ADDR_W-1:0] MEM_LAST  = '1;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_FAST = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;
endpackage

// File: rtl/dbg_tx_frame.sv
// Status frame transmitter: snapshots {pc, cycle count} and shifts it out MSB byte first over the UART.
module dbg_tx_frame
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] pc,
    input  logic [31:0] cnt,
    input  logic        send,
    input  logic        wait_tx,
    input  logic        tx_done,
    output logic [7:0]  data_send,
    output logic        tx_start,
    output logic        frame_done
);
    localparam int IDX_W = $clog2(FRAME_BYTES);

    logic [63:0]      snap;
    logic [IDX_W-1:0] idx;
    logic             byte_done;

    assign byte_done  = wait_tx && tx_done;
    assign frame_done = byte_done && (idx == IDX_W'(FRAME_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            snap      <= '0;
            idx       <= '0;
            data_send <= '0;
            tx_start  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (load) begin
                snap <= {pc, cnt};
                idx  <= '0;
            end
            if (send) begin
                data_send <= snap[63:56];
                tx_start  <= 1'b1;
            end
            // The snapshot is consumed as a shift register; the top byte is always the next one out.
            if (byte_done) begin
                snap <= {snap[55:0], 8'h00};
                idx  <= frame_done ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: loads instruction memory, runs or single-steps the pipeline, reports PC and cycle count.
module debug_unit
    import debug_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_done,
    input  logic [7:0]            i_data,
    input  logic                  i_tx_done,
    input  logic                  i_halt,
    input  logic [31:0]           i_pc,
    output logic [7:0]            o_data_send,
    output logic                  o_tx_start,
    output logic                  o_cpu_enable,
    output logic                  o_mem_we,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data
);
    state_t                state, state_next;
    logic [MEM_ADDR_W-1:0] word_addr;
    logic [1:0]            byte_cnt;
    logic [31:0]           asm_word;
    logic [31:0]           cycle_cnt;
    logic [31:0]           cnt_next;
    logic                  frame_done;
    logic                  snap_load;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if (i_data == CMD_LOAD)      state_next = ST_LOAD;
                    else if (i_data == CMD_STEP) state_next = i_halt ? ST_SEND : ST_STEP;
                    else if (i_data == CMD_FAST) state_next = ST_RUN;
                end
            end
            ST_LOAD:    if (i_rx_done && byte_cnt == 2'd3) state_next = ST_LOAD_WR;
            ST_LOAD_WR: state_next = (o_mem_data == HALT_WORD || o_mem_addr == MEM_LAST) ? ST_IDLE : ST_LOAD;
            ST_RUN:     if (i_halt) state_next = ST_SEND;
            ST_STEP:    state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (frame_done)     state_next = ST_IDLE;
                else if (i_tx_done) state_next = ST_SEND;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // The snapshot must include the enable cycle retiring on the same edge, hence cnt_next.
    assign cnt_next  = cycle_cnt + {31'd0, o_cpu_enable};
    assign snap_load = (state_next == ST_SEND) && (state != ST_WAIT_TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            o_cpu_enable <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            word_addr    <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            cycle_cnt    <= '0;
        end else begin
            state        <= state_next;
            o_cpu_enable <= (state_next == ST_RUN) || (state_next == ST_STEP);
            o_mem_we     <= (state_next == ST_LOAD_WR);
            cycle_cnt    <= cnt_next;
            if (state == ST_IDLE && state_next == ST_LOAD) begin
                word_addr <= '0;
                byte_cnt  <= '0;
                cycle_cnt <= '0;
            end
            if (state == ST_LOAD && i_rx_done) begin
                asm_word <= {asm_word[23:0], i_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state_next == ST_LOAD_WR) begin
                o_mem_addr <= word_addr;
                o_mem_data <= {asm_word[23:0], i_data};
            end
            if (state == ST_LOAD_WR && word_addr != MEM_LAST)
                word_addr <= word_addr + 1'b1;
        end
    end

    dbg_tx_frame u_tx_frame (
        .clk        (clk),
        .rst        (rst),
        .load       (snap_load),
        .pc         (i_pc),
        .cnt        (cnt_next),
        .send       (state == ST_SEND),
        .wait_tx    (state == ST_WAIT_TX),
        .tx_done    (i_tx_done),
        .data_send  (o_data_send),
        .tx_start   (o_tx_start),
        .frame_done (frame_done)
    );
endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: scenario tasks against a transaction-level model of loads, runs and status frames.
module tb_debug_unit;
    import debug_pkg::*;

    logic        clk, rst, i_rx_done, i_tx_done, i_halt;
    logic [7:0]  i_data;
    logic [31:0] i_pc;
    logic [7:0]  o_data_send;
    logic        o_tx_start, o_cpu_enable, o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  got_tx[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] load_words[$];
    int          en_cycles;
    bit          timed_out;

    logic [31:0] model_cnt;
    logic [7:0]  model_last_tx;
    logic [7:0]  model_last_addr;
    logic [31:0] model_last_data;

    debug_unit dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_done    (i_rx_done),
        .i_data       (i_data),
        .i_tx_done    (i_tx_done),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .o_data_send  (o_data_send),
        .o_tx_start   (o_tx_start),
        .o_cpu_enable (o_cpu_enable),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_tx_start) got_tx.push_back(o_data_send);
        if (o_mem_we) begin
            got_addr.push_back(o_mem_addr);
            got_data.push_back(o_mem_data);
        end
        if (o_cpu_enable) en_cycles++;
    end

    // Reference model: the frame is simply {pc, cycles enabled so far} sent MSB byte first.
    function automatic void build_frame(input logic [31:0] pc, input logic [31:0] cnt);
        logic [63:0] f;
        f = {pc, cnt};
        exp_q.delete();
        for (int i = 0; i < FRAME_BYTES; i++) begin
            exp_q.push_back(f[63:56]);
            f = f << 8;
        end
        model_last_tx = cnt[7:0];
    endfunction

    // Reference model: word i lands at address i; loading stops after the halt word or address 255.
    function automatic void build_writes();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < load_words.size(); i++) begin
            exp_addr_q.push_back(8'(i));
            exp_data_q.push_back(load_words[i]);
            model_last_addr = 8'(i);
            model_last_data = load_words[i];
            if (load_words[i] == HALT_WORD || i == 255) break;
        end
        model_cnt = 0;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt       = 0;
        model_last_tx   = 0;
        model_last_addr = 0;
        model_last_data = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_data    = b;
        i_rx_done = 1'b1;
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic collect_frame(input bit hold);
        timed_out = 1'b1;
        for (int c = 0; c < 800; c++) begin
            i_tx_done = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (dut.state == ST_IDLE) begin
                timed_out = 1'b0;
                break;
            end
        end
        i_tx_done = 1'b0;
    endtask

    task automatic drive_load();
        got_addr.delete();
        got_data.delete();
        send_byte(CMD_LOAD, 0);
        foreach (load_words[w]) begin
            for (int b = 3; b >= 0; b--)
                send_byte(load_words[w][8*b +: 8], $urandom_range(1, 3));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (o_tx_start !== 1'b0 || o_cpu_enable !== 1'b0 || o_mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: tx_start=%b cpu_enable=%b mem_we=%b, required all 0", o_tx_start, o_cpu_enable, o_mem_we);
        end
        tests_run++;
        if (o_data_send !== 8'h00 || o_mem_addr !== 8'h00 || o_mem_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: data_send=%h mem_addr=%h mem_data=%h, required 0", o_data_send, o_mem_addr, o_mem_data);
        end
        tests_run++;
        if (dut.state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, required IDLE", dut.state);
        end
    endtask

    task automatic test_load_vector();
        load_words = '{32'h01020304, 32'h8040C020, 32'hFFFFFFFF};
        build_writes();
        drive_load();
        tests_run++;
        if (got_addr.size() !== exp_addr_q.size()) begin
            tests_failed++;
            $display("FAIL load_vec_count: got %0d writes, required %0d", got_addr.size(), exp_addr_q.size());
        end
        for (int i = 0; i < exp_addr_q.size() && i < got_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr_q[i] || got_data[i] !== exp_data_q[i]) begin
                tests_failed++;
                $display("FAIL load_vec_write%0d: got %h@%h, required %h@%h", i, got_data[i], got_addr[i], exp_data_q[i], exp_addr_q[i]);
            end
        end
        tests_run++;
        if (dut.state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL load_vec_idle: state %0d, required IDLE", dut.state);
        end
    endtask

    task automatic test_fast(input int k, input logic [31:0] pc, input bit hold);
        i_pc = pc;
        got_tx.delete();
        en_cycles = 0;
        send_byte(CMD_FAST, 0);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        i_halt = 1'b1;
        @(posedge clk);
        #1;
        i_halt = 1'b0;
        collect_frame(hold);
        model_cnt += k;
        build_frame(pc, model_cnt);
        tests_run++;
        if (timed_out || en_cycles !== k) begin
            tests_failed++;
            $display("FAIL fast_enable: enable cycles %0d timeout %0b, required %0d cycles", en_cycles, timed_out, k);
        end
        tests_run++;
        if (got_tx.size() !== FRAME_BYTES) begin
            tests_failed++;
            $display("FAIL fast_frame_len: got %0d bytes, required %0d", got_tx.size(), FRAME_BYTES);
        end
        for (int i = 0; i < FRAME_BYTES && i < got_tx.size(); i++) begin
            tests_run++;
            if (got_tx[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL fast_byte%0d: got %h, required %h", i, got_tx[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_step(input bit halted, input bit hold);
        i_pc = $urandom;
        got_tx.delete();
        en_cycles = 0;
        i_halt = halted;
        send_byte(CMD_STEP, 0);
        i_halt = 1'b0;
        collect_frame(hold);
        if (!halted) model_cnt += 1;
        build_frame(i_pc, model_cnt);
        tests_run++;
        if (timed_out || en_cycles !== (halted ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL step_enable: enable cycles %0d timeout %0b, required %0d", en_cycles, timed_out, halted ? 0 : 1);
        end
        tests_run++;
        if (got_tx.size() !== FRAME_BYTES) begin
            tests_failed++;
            $display("FAIL step_frame_len: got %0d bytes, required %0d", got_tx.size(), FRAME_BYTES);
        end
        for (int i = 0; i < FRAME_BYTES && i < got_tx.size(); i++) begin
            tests_run++;
            if (got_tx[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL step_byte%0d: got %h, required %h", i, got_tx[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_step_twice();
        apply_reset();
        test_step(1'b0, 1'($urandom_range(0, 1)));
        test_step(1'b0, 1'($urandom_range(0, 1)));
        tests_run++;
        if (got_tx.size() == FRAME_BYTES && got_tx[7] !== 8'h02) begin
            tests_failed++;
            $display("FAIL step_twice_cnt: last byte %h, required 02", got_tx[7]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int starts;
        bit hit;
        starts = 0;
        hit = 1'b0;
        i_pc = $urandom;
        send_byte(CMD_STEP, 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_tx_start) starts++;
            if (starts >= 3) begin
                hit = 1'b1;
                break;
            end
            i_tx_done = 1'b1;
        end
        i_tx_done = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0; model_last_tx = 0; model_last_addr = 0; model_last_data = 0;
        tests_run++;
        if (!hit || dut.state !== ST_IDLE || o_tx_start !== 1'b0 || o_cpu_enable !== 1'b0 || o_mem_we !== 1'b0 ||
            o_data_send !== 8'h00 || o_mem_addr !== 8'h00 || o_mem_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_frame_reset: reached=%0b state=%0d start=%b en=%b we=%b data=%h addr=%h word=%h, required IDLE and all 0",
                     hit, dut.state, o_tx_start, o_cpu_enable, o_mem_we, o_data_send, o_mem_addr, o_mem_data);
        end
        test_step(1'b0, 1'b0);
    endtask

    task automatic test_load_full();
        load_words.delete();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == HALT_WORD) w = 32'h0;
            load_words.push_back(w);
        end
        build_writes();
        drive_load();
        tests_run++;
        if (got_addr.size() !== 256) begin
            tests_failed++;
            $display("FAIL load_full_count: got %0d writes, required 256", got_addr.size());
        end
        for (int i = 0; i < 256 && i < got_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr_q[i] || got_data[i] !== exp_data_q[i]) begin
                tests_failed++;
                $display("FAIL load_full_write%0d: got %h@%h, required %h@%h", i, got_data[i], got_addr[i], exp_data_q[i], exp_addr_q[i]);
            end
        end
        tests_run++;
        if (dut.state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL load_full_idle: state %0d, required IDLE", dut.state);
        end
    endtask

    task automatic test_bad_cmd();
        got_addr.delete();
        send_byte(8'h07, 0);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (dut.state !== ST_IDLE || o_tx_start !== 1'b0 || o_cpu_enable !== 1'b0 || o_mem_we !== 1'b0 ||
                o_data_send !== model_last_tx || o_mem_addr !== model_last_addr || o_mem_data !== model_last_data) begin
                tests_failed++;
                $display("FAIL bad_cmd_c%0d: state=%0d start=%b en=%b we=%b data=%h addr=%h word=%h, required IDLE 0 0 0 %h %h %h",
                         c, dut.state, o_tx_start, o_cpu_enable, o_mem_we, o_data_send, o_mem_addr, o_mem_data,
                         model_last_tx, model_last_addr, model_last_data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; i_rx_done = 1'b0; i_data = 8'h00; i_tx_done = 1'b0; i_halt = 1'b0; i_pc = 32'h0;
        en_cycles = 0;
        test_reset();
        test_load_vector();
        test_fast(5, 32'h0000_0014, 1'b1);
        test_step_twice();
        test_step(1'b1, 1'b1);
        for (int r = 0; r < 3; r++)
            test_fast($urandom_range(1, 20), $urandom, 1'b0);
        test_reset_mid_frame();
        test_load_full();
        test_bad_cmd();
        test_step(1'b0, 1'b1);
        test_bad_cmd();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
